mem_port_arbiter: RTL

- Shares the single main-memory controller command/read/write port between two requesters: the VGA line buffer (high priority, hard real-time) and the CPU/graphics-write path (low priority).
- Grants whole transactions. The granted requester's command, read and write strobes are forwarded to the memory port, and the other requester's strobes are blocked.
- Sits between both requesters and the memory controller port. It asks a low-priority holder to yield when VGA is waiting, and flags VGA starvation.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_arb_hold_timer.sv | 36 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encodings,
// memory instruction codes, the command bundle type and a saturating helper.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_GNT_VGA = 2'd1;
  localparam logic [1:0] ARB_GNT_CPU = 2'd2;
  localparam logic [1:0] ARB_TURN    = 2'd3;

  localparam logic [2:0] MEM_INSTR_WR = 3'b000;
  localparam logic [2:0] MEM_INSTR_RD = 3'b001;

  typedef struct packed {
    logic        en;
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
  } mem_cmd_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arb_hold_timer.sv
// Saturating VGA wait counter with a sticky starvation flag; the flag
// only clears on reset, while clr restarts the count.
module mem_arb_hold_timer #(
  parameter int HOLD_MAX = 64,
  parameter int TIMER_W  = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  input  logic clr,
  output logic starve
);

  localparam logic [TIMER_W-1:0] LIMIT    = TIMER_W'(HOLD_MAX);
  localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(HOLD_MAX - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      starve <= 1'b0;
    end else begin
      if (clr) begin
        count <= '0;
      end else if (count_en && count != LIMIT) begin
        count <= count + 1'b1;
      end
      // Flag rises on the same edge the count lands on HOLD_MAX.
      if (!clr && count_en && count >= LIMIT_M1) begin
        starve <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester transaction arbiter for the memory controller port (VGA high
// priority, CPU low). Define MEM_ARB_STATS_EN to add grant/yield counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 64,
  parameter int TIMER_W  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        calib_done,
  input  logic        vga_req,
  output logic        vga_gnt,
  input  logic        vga_cmd_en,
  input  logic [2:0]  vga_cmd_instr,
  input  logic [5:0]  vga_cmd_bl,
  input  logic [29:0] vga_cmd_byte_addr,
  input  logic        vga_rd_en,
  input  logic        cpu_req,
  output logic        cpu_gnt,
  input  logic        cpu_cmd_en,
  input  logic [2:0]  cpu_cmd_instr,
  input  logic [5:0]  cpu_cmd_bl,
  input  logic [29:0] cpu_cmd_byte_addr,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_wr_data,
  input  logic [3:0]  cpu_wr_mask,
  output logic        cpu_yield,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0] stat_vga_grants,
  output logic [15:0] stat_cpu_grants,
  output logic [15:0] stat_yields,
`endif
  output logic        arb_starve
);

  logic [1:0] state;
  logic [1:0] next_state;
  logic       yield_next;
  mem_cmd_t   cmd_sel;

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE: begin
        if (calib_done && vga_req)      next_state = ARB_GNT_VGA;
        else if (calib_done && cpu_req) next_state = ARB_GNT_CPU;
      end
      ARB_GNT_VGA: if (!vga_req) next_state = ARB_TURN;
      ARB_GNT_CPU: if (!cpu_req) next_state = ARB_TURN;
      default:     next_state = ARB_IDLE;
    endcase
  end

  assign yield_next = (state == ARB_GNT_CPU) && vga_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      cpu_yield <= 1'b0;
    end else begin
      state     <= next_state;
      cpu_yield <= yield_next;
    end
  end

  assign vga_gnt = (state == ARB_GNT_VGA);
  assign cpu_gnt = (state == ARB_GNT_CPU);

  // Zero-latency port mux; no owner means every strobe and field is zero.
  always_comb begin
    cmd_sel     = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    mem_wr_mask = '0;
    if (vga_gnt) begin
      cmd_sel   = '{vga_cmd_en, vga_cmd_instr, vga_cmd_bl, vga_cmd_byte_addr};
      mem_rd_en = vga_rd_en;
    end else if (cpu_gnt) begin
      cmd_sel     = '{cpu_cmd_en, cpu_cmd_instr, cpu_cmd_bl, cpu_cmd_byte_addr};
      mem_rd_en   = cpu_rd_en;
      mem_wr_en   = cpu_wr_en;
      mem_wr_data = cpu_wr_data;
      mem_wr_mask = cpu_wr_mask;
    end
  end

  assign mem_cmd_en        = cmd_sel.en;
  assign mem_cmd_instr     = cmd_sel.instr;
  assign mem_cmd_bl        = cmd_sel.bl;
  assign mem_cmd_byte_addr = cmd_sel.addr;

  mem_arb_hold_timer #(
    .HOLD_MAX (HOLD_MAX),
    .TIMER_W  (TIMER_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (yield_next),
    .clr      (state != ARB_GNT_CPU),
    .starve   (arb_starve)
  );

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_vga_grants <= '0;
      stat_cpu_grants <= '0;
      stat_yields     <= '0;
    end else begin
      if (state == ARB_IDLE && next_state == ARB_GNT_VGA)
        stat_vga_grants <= sat_inc16(stat_vga_grants);
      if (state == ARB_IDLE && next_state == ARB_GNT_CPU)
        stat_cpu_grants <= sat_inc16(stat_cpu_grants);
      if (yield_next && !cpu_yield)
        stat_yields <= sat_inc16(stat_yields);
    end
  end
`endif

endmodule
